semaforo_temporizador: RTL and testbench

Timing controller that drives the `pulso` input of the `semaforo` traffic-light FSM. It watches the light outputs `vermelho`, `verde` and `amarelo`, and waits a programmable dwell time for each colour. It then emits a clean, finite-length advance pulse, so the light controller's edge detector sees one rising edge per phase. It also handles a pedestrian request, which shortens the green phase, and it flags a sticky error if the light fails to change after a pulse.

---
 rtl/semaforo_temporizador.sv | 161 ++++++++++++++++
 tb/tb_semaforo_temporizador.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/semaforo_temporizador.sv
// rtl/semaforo_temporizador.sv - dwell timer that paces the semaforo light FSM through its pulso input
// Times each colour, emits a fixed-length advance pulse, shortens green on a pedestrian request, flags a stuck light.
module semaforo_temporizador #(
  parameter int CW         = 16,
  parameter int T_VERMELHO = 8,
  parameter int T_VERDE    = 6,
  parameter int T_AMARELO  = 3,
  parameter int T_PED      = 2,
  parameter int PULSE_LEN  = 2,
  parameter int TIMEOUT    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vermelho,
  input  logic          verde,
  input  logic          amarelo,
  input  logic          botao_pedestre,
  output logic          pulso,
  output logic          pedido_ativo,
  output logic          erro,
  output logic [CW-1:0] restante
);

  if (longint'(T_VERMELHO) >= (longint'(1) << CW) || longint'(T_VERDE) >= (longint'(1) << CW) ||
      longint'(T_AMARELO) >= (longint'(1) << CW) || longint'(T_PED) >= (longint'(1) << CW) ||
      longint'(PULSE_LEN) >= (longint'(1) << CW) || longint'(TIMEOUT) >= (longint'(1) << CW) ||
      T_VERMELHO < 1 || T_VERDE < 1 || T_AMARELO < 1 || PULSE_LEN < 1 || TIMEOUT < 1 ||
      T_PED < 1 || T_PED > T_VERDE) begin : g_param_check
    $error("semaforo_temporizador: timing parameter out of range for CW");
  end

  typedef enum logic [1:0] {ESPERA, CONTANDO, PULSANDO, AGUARDA} estado_t;

  localparam logic [2:0] LUZ_VERMELHO = 3'b100;
  localparam logic [2:0] LUZ_VERDE    = 3'b010;
  localparam logic [2:0] LUZ_AMARELO  = 3'b001;

  estado_t       estado_q, estado_d;
  logic [2:0]    luz_ref_q, luz_ref_d, luz_ant_q;
  logic [CW-1:0] restante_q, restante_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulso_q, pulso_d;
  logic          erro_q, erro_d;
  logic          pedido_q, pedido_d;
  logic          sync1_q, sync2_q, sync3_q;

  logic [2:0]    luz;
  logic          valido, mudou, sobe, limpa;

  function automatic logic [CW-1:0] dwell_menos_um(input logic [2:0] p);
    case (p)
      LUZ_VERMELHO: dwell_menos_um = CW'(T_VERMELHO - 1);
      LUZ_VERDE:    dwell_menos_um = CW'(T_VERDE - 1);
      default:      dwell_menos_um = CW'(T_AMARELO - 1);
    endcase
  endfunction

  assign luz    = {vermelho, verde, amarelo};
  assign valido = (luz == LUZ_VERMELHO) || (luz == LUZ_VERDE) || (luz == LUZ_AMARELO);
  assign mudou  = valido && (luz != luz_ref_q);
  assign sobe   = sync2_q & ~sync3_q;
  assign limpa  = (luz == LUZ_VERMELHO) && (luz_ant_q != LUZ_VERMELHO);

  always_comb begin
    estado_d   = estado_q;
    luz_ref_d  = luz_ref_q;
    restante_d = restante_q;
    cnt_d      = cnt_q;
    pulso_d    = pulso_q;
    erro_d     = erro_q;
    // A new red phase ends the pedestrian cycle; a press arriving on that same edge is dropped.
    pedido_d   = limpa ? 1'b0 : (sobe ? 1'b1 : pedido_q);

    if (!valido) begin
      estado_d   = ESPERA;
      pulso_d    = 1'b0;
      restante_d = '0;
    end else begin
      case (estado_q)
        ESPERA: begin
          pulso_d    = 1'b0;
          luz_ref_d  = luz;
          restante_d = dwell_menos_um(luz);
          estado_d   = CONTANDO;
        end
        CONTANDO: begin
          if (mudou) begin
            luz_ref_d  = luz;
            restante_d = dwell_menos_um(luz);
          end else if (restante_q == '0) begin
            estado_d = PULSANDO;
            pulso_d  = 1'b1;
            cnt_d    = CW'(PULSE_LEN - 1);
          end else if (pedido_q && luz_ref_q == LUZ_VERDE && restante_q >= CW'(T_PED)) begin
            restante_d = CW'(T_PED - 1);
          end else begin
            restante_d = restante_q - 1'b1;
          end
        end
        PULSANDO: begin
          pulso_d = 1'b1;
          if (cnt_q == '0) begin
            pulso_d  = 1'b0;
            cnt_d    = CW'(TIMEOUT - 1);
            estado_d = AGUARDA;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        AGUARDA: begin
          pulso_d = 1'b0;
          if (mudou) begin
            luz_ref_d  = luz;
            restante_d = dwell_menos_um(luz);
            estado_d   = CONTANDO;
          end else if (cnt_q == '0) begin
            erro_d   = 1'b1;
            estado_d = ESPERA;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: estado_d = ESPERA;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q   <= ESPERA;
      luz_ref_q  <= '0;
      luz_ant_q  <= '0;
      restante_q <= '0;
      cnt_q      <= '0;
      pulso_q    <= 1'b0;
      erro_q     <= 1'b0;
      pedido_q   <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      luz_ref_q  <= luz_ref_d;
      luz_ant_q  <= luz;
      restante_q <= restante_d;
      cnt_q      <= cnt_d;
      pulso_q    <= pulso_d;
      erro_q     <= erro_d;
      pedido_q   <= pedido_d;
      sync1_q    <= botao_pedestre;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
    end
  end

  assign pulso        = pulso_q;
  assign pedido_ativo = pedido_q;
  assign erro         = erro_q;
  assign restante     = restante_q;

endmodule

// File: tb/tb_semaforo_temporizador.sv
// tb/tb_semaforo_temporizador.sv - directed bench with a timestamp-based reference model for semaforo_temporizador
module tb_semaforo_temporizador;
  localparam int CW = 16, TV = 8, TG = 6, TA = 3, TP = 2, PL = 2, TO = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vermelho = 1'b1, verde = 1'b0, amarelo = 1'b0;
  logic          botao = 1'b0;
  logic          pulso, pedido, erro;
  logic [CW-1:0] restante;

  semaforo_temporizador #(
    .CW(CW), .T_VERMELHO(TV), .T_VERDE(TG), .T_AMARELO(TA),
    .T_PED(TP), .PULSE_LEN(PL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .vermelho(vermelho), .verde(verde), .amarelo(amarelo),
    .botao_pedestre(botao), .pulso(pulso), .pedido_ativo(pedido), .erro(erro), .restante(restante)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: tracks absolute edge numbers of the next pulse, not controller states.
  int         n;
  logic [2:0] pat_hist [0:4095];
  logic       btn_hist [0:4095];
  bit         m_active, m_erro, m_ped;
  logic [2:0] m_ref;
  int         m_fire;
  logic [2:0] pend_pat = 3'b100;
  logic       pend_btn = 1'b0;
  logic       pend_rst = 1'b1;

  function automatic int dwell(input logic [2:0] p);
    if (p == 3'b100) return TV;
    if (p == 3'b010) return TG;
    return TA;
  endfunction

  task automatic model_reset();
    n = 0; m_active = 0; m_erro = 0; m_ped = 0; m_ref = 3'b000; m_fire = 0;
  endtask

  task automatic model_edge(input logic [2:0] p, input logic b);
    bit valid, ped_old, rise, clr;
    logic [2:0] prevp;
    pat_hist[n % 4096] = p;
    btn_hist[n % 4096] = b;
    valid   = (p == 3'b100) || (p == 3'b010) || (p == 3'b001);
    ped_old = m_ped;
    if (!valid) m_active = 0;
    else if (!m_active || (n <= m_fire && p != m_ref) || (n > m_fire + PL && p != m_ref)) begin
      m_active = 1; m_ref = p; m_fire = n + dwell(p);
    end else if (n < m_fire) begin
      if (ped_old && m_ref == 3'b010 && (m_fire - n) >= TP) m_fire = n + TP;
    end else if (n == m_fire + PL + TO) begin
      m_erro = 1; m_active = 0;
    end
    rise  = (n >= 2 && btn_hist[(n - 2) % 4096]) && !(n >= 3 && btn_hist[(n - 3) % 4096]);
    prevp = (n >= 1) ? pat_hist[(n - 1) % 4096] : 3'b000;
    clr   = (p == 3'b100) && (prevp != 3'b100);
    m_ped = clr ? 1'b0 : (rise ? 1'b1 : m_ped);
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (pend_rst || reset) model_reset();
      else begin
        model_edge(pend_pat, pend_btn);
        chk("cyc pulso", 32'(pulso), 32'(m_active && n >= m_fire && n < m_fire + PL));
        chk("cyc pedido", 32'(pedido), 32'(m_ped));
        chk("cyc erro", 32'(erro), 32'(m_erro));
        chk("cyc restante", 32'(restante), (m_active && n < m_fire) ? 32'(m_fire - n - 1) : 32'd0);
        n++;
      end
      pend_pat = {vermelho, verde, amarelo};
      pend_btn = botao;
      pend_rst = reset;
    end
  end

  // Stimulus: inputs change 2 time units after each rising edge; optional closed-loop light stand-in.
  bit closed = 0;
  bit pulso_seen = 0, ped_seen = 0;
  int ped_rises = 0;

  task automatic setl(input logic [2:0] p);
    {vermelho, verde, amarelo} = p;
  endtask

  task automatic tick(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #2;
      if (closed && pulso && !pulso_seen) begin
        case ({vermelho, verde, amarelo})
          3'b100:  setl(3'b010);
          3'b010:  setl(3'b001);
          default: setl(3'b100);
        endcase
      end
      if (pedido && !ped_seen) ped_rises++;
      pulso_seen = pulso;
      ped_seen   = pedido;
    end
  endtask

  initial begin
    tick(3);
    chk("reset pulso", 32'(pulso), 0);
    chk("reset pedido", 32'(pedido), 0);
    chk("reset erro", 32'(erro), 0);
    chk("reset restante", 32'(restante), 0);

    // Closed loop from red; afterwards tick(j) leaves us just after edge j-1.
    closed = 1; reset = 0;
    tick(8); chk("red pulso e7", 32'(pulso), 0);
    tick(1); chk("red pulso e8", 32'(pulso), 1);
    tick(1); chk("red pulso e9", 32'(pulso), 1);
    tick(1); chk("red pulso e10", 32'(pulso), 0);
    tick(1); chk("green restante e11", 32'(restante), 5);
    botao = 1;
    tick(1); botao = 0;
    tick(1); chk("ped e13", 32'(pedido), 0);
    tick(1); chk("ped e14", 32'(pedido), 1);
    chk("green restante e14", 32'(restante), 2);
    tick(1); chk("clamp e15", 32'(restante), 1);
    tick(1); chk("clamp pulso e16", 32'(pulso), 0);
    tick(1); chk("clamp pulso e17", 32'(pulso), 1);
    tick(6); chk("ped held e23", 32'(pedido), 1);
    tick(1); chk("ped clear e24", 32'(pedido), 0);
    tick(90); chk("loop erro", 32'(erro), 0);

    // Open loop with green stuck on.
    reset = 1; closed = 0;
    tick(2);
    reset = 0; setl(3'b010);
    tick(6); chk("open pulso e5", 32'(pulso), 0);
    tick(1); chk("open pulso e6", 32'(pulso), 1);
    tick(1); chk("open pulso e7", 32'(pulso), 1);
    tick(1); chk("open pulso e8", 32'(pulso), 0);
    tick(4); chk("open erro e12", 32'(erro), 0);
    tick(1); chk("open erro e13", 32'(erro), 1);
    tick(6); chk("open repulse e19", 32'(pulso), 0);
    tick(1); chk("open repulse e20", 32'(pulso), 1);
    chk("open erro sticky", 32'(erro), 1);

    // Invalid pattern during the pulse, then during counting.
    setl(3'b110);
    tick(1); chk("inv pulse pulso", 32'(pulso), 0);
    chk("inv pulse restante", 32'(restante), 0);
    setl(3'b100);
    tick(1); chk("inv restart e22", 32'(restante), 7);
    tick(3); chk("inv count e25", 32'(restante), 4);
    setl(3'b110);
    tick(1); chk("inv count restante", 32'(restante), 0);
    chk("inv count pulso", 32'(pulso), 0);
    setl(3'b100);
    tick(1); chk("inv restart e27", 32'(restante), 7);
    tick(8); chk("inv pulse e35", 32'(pulso), 1);

    // Asynchronous reset while the pulse is high.
    #1 reset = 1;
    #1;
    chk("async pulso", 32'(pulso), 0);
    chk("async erro", 32'(erro), 0);
    chk("async pedido", 32'(pedido), 0);
    chk("async restante", 32'(restante), 0);
    tick(2);
    reset = 0; closed = 1;
    tick(8); chk("post rst e7", 32'(pulso), 0);
    tick(1); chk("post rst e8", 32'(pulso), 1);

    // Held button gives one request.
    botao = 1; ped_rises = 0;
    tick(40); botao = 0;
    tick(4); chk("held rises", 32'(ped_rises), 1);

    // Press synchronised on the very edge red is entered is lost.
    closed = 0;
    setl(3'b001); tick(2);
    setl(3'b100); tick(2);
    setl(3'b001); tick(4);
    chk("prio pre", 32'(pedido), 0);
    botao = 1;
    tick(2); setl(3'b100);
    tick(1); chk("prio lost", 32'(pedido), 0);
    tick(3); chk("prio still", 32'(pedido), 0);
    botao = 0;
    tick(3); botao = 1;
    tick(3); chk("press sets", 32'(pedido), 1);
    botao = 0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
